// File: rtl/accum_sequencer.sv
// -----------------------------------------------------------------------------
// accum_sequencer
//
// Drives a shared WIDTH-bit ripple-carry adder as a multi-operand accumulator.
// A run starts with a count (num_ops). That many operands are then accepted
// over a valid/ready handshake. Each operand is added into the accumulator
// through the external adder. The final sum is presented on result, with a
// sticky carry-out flag (ovf) and a one-cycle done pulse.
//
// Optional feature (compile-time macro):
//   ACCUM_SAT_EN - on any carry-out the accumulator saturates to all-ones
//                  instead of wrapping. When undefined the accumulator wraps
//                  modulo 2**WIDTH. ovf is sticky in both builds.
//
// Ports:
//   Clk       in   clock, rising edge
//   reset     in   asynchronous reset, active-high
//   start     in   begin a run (sampled only while idle)
//   num_ops   in   operand count for the run, sampled with start
//   op_valid  in   operand present on op_data
//   op_data   in   operand value
//   op_ready  out  operand accepted this cycle (registered)
//   add_a     out  adder A input (accumulator register)
//   add_b     out  adder B input (operand register)
//   add_cin   out  adder carry-in, tied to 0
//   add_sum   in   adder sum
//   add_cout  in   adder carry-out
//   result    out  accumulator value, held until the next accepted start
//   ovf       out  sticky: some add in this run produced a carry-out
//   busy      out  high whenever not idle
//   done      out  one-cycle pulse when result/ovf are final
// -----------------------------------------------------------------------------
module accum_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OP = 2'd1,
        ADD     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opreg;
    logic [CNT_W-1:0] remaining;

    // The adder sees the registers directly, so the sum is stable for a whole
    // ADD cycle and no combinational path runs from the handshake into it.
    assign add_a   = acc;
    assign add_b   = opreg;
    assign add_cin = 1'b0;
    assign result  = acc;

    // op_ready, busy and done are registered. Each transition sets them for
    // the state being entered, so they always decode the current state.
    // NOTE: every register in this block is assigned with <= so all of them
    // update together from the values present before the clock edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            opreg     <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
            op_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (num_ops != '0) begin
                            remaining <= num_ops;
                            op_ready  <= 1'b1;
                            state     <= WAIT_OP;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                WAIT_OP: begin
                    // Waits as long as needed; there is no timeout.
                    if (op_valid) begin
                        opreg    <= op_data;
                        op_ready <= 1'b0;
                        state    <= ADD;
                    end
                end

                ADD: begin
`ifdef ACCUM_SAT_EN
                    // Once saturated, later adds either carry again or add
                    // zero, so the accumulator stays at all-ones.
                    if (add_cout) begin
                        acc <= '1;
                    end else begin
                        acc <= add_sum;
                    end
`else
                    acc <= add_sum;
`endif
                    ovf       <= ovf | add_cout;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        op_ready <= 1'b1;
                        state    <= WAIT_OP;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    op_ready <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_sequencer.sv
// -----------------------------------------------------------------------------
// tb_accum_sequencer
//
// Self-checking bench for accum_sequencer. A behavioural adder drives the
// add_* ports. Expected sums and overflow come from plain integer arithmetic
// over the operand list. With ACCUM_SAT_EN defined, the expected values
// follow the saturating rule.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_accum_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             Clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    int ops_buf [16];
    int gap_buf [16];

    always #5 Clk = ~Clk;

    // Behavioural stand-in for the 8-bit ripple-carry adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    accum_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .num_ops  (num_ops),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_ready (op_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .result   (result),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " op_ready"}, op_ready, 0);
        check({tag, " busy"},     busy,     0);
        check({tag, " done"},     done,     0);
        check({tag, " result"},   result,   0);
        check({tag, " ovf"},      ovf,      0);
        check({tag, " add_a"},    add_a,    0);
        check({tag, " add_b"},    add_b,    0);
        check({tag, " add_cin"},  add_cin,  0);
    endtask

    // Reference: one accumulation step, from the arithmetic rules alone.
    function automatic void model_add(inout int acc_m, inout int ovf_m, input int op);
        int s;
        s = acc_m + op;
        if (s > MAXV) begin
            ovf_m = 1;
`ifdef ACCUM_SAT_EN
            acc_m = MAXV;
`else
            acc_m = s % (MAXV + 1);
`endif
        end else begin
            acc_m = s;
        end
    endfunction

    // Runs one accumulation of n operands from ops_buf, with gap_buf idle
    // cycles before each. Call just after a falling edge with the DUT idle.
    // If stop_after is nonzero, returns after that many operands
    // (used for the mid-run reset). If inject is set, start is pulsed with
    // num_ops=1 during the idle gap before the second operand.
    task automatic run(input int n, input int stop_after, input bit inject);
        int acc_m = 0;
        int ovf_m = 0;
        int limit;
        limit = (stop_after != 0) ? stop_after : n;
        check("idle busy before start", busy, 0);
        start   = 1'b1;
        num_ops = CNT_W'(n);
        @(negedge Clk);
        start   = 1'b0;
        num_ops = '0;
        check("busy after start", busy, 1);
        check("result cleared", result, 0);
        check("ovf cleared", ovf, 0);
        if (n == 0) begin
            check("zero-op done", done, 1);
            check("zero-op op_ready", op_ready, 0);
            @(negedge Clk);
            check("zero-op done pulse width", done, 0);
            check("zero-op busy after", busy, 0);
            check("zero-op result held", result, 0);
            return;
        end
        check("no early done", done, 0);
        for (int k = 0; k < limit; k++) begin
            for (int g = 0; g < gap_buf[k]; g++) begin
                check("op_ready while waiting", op_ready, 1);
                check("acc stable while waiting", result, acc_m);
                if (inject && k == 1 && g == 0) begin
                    start   = 1'b1;
                    num_ops = CNT_W'(1);
                end
                op_valid = 1'b0;
                @(negedge Clk);
                start   = 1'b0;
                num_ops = '0;
            end
            check("op_ready at handshake", op_ready, 1);
            op_valid = 1'b1;
            op_data  = WIDTH'(ops_buf[k]);
            @(negedge Clk);
            op_valid = 1'b0;
            op_data  = $urandom_range(0, MAXV);
            check("op_ready low in ADD", op_ready, 0);
            check("add_b holds operand", add_b, ops_buf[k]);
            check("add_a holds acc", add_a, acc_m);
            check("done low in ADD", done, 0);
            @(negedge Clk);
            model_add(acc_m, ovf_m, ops_buf[k]);
            check("partial sum", result, acc_m);
            check("partial ovf", ovf, ovf_m);
            if (k == n - 1) begin
                check("done after last op", done, 1);
                check("op_ready low in DONE", op_ready, 0);
                @(negedge Clk);
                check("done pulse width", done, 0);
                check("busy after done", busy, 0);
                check("result held", result, acc_m);
                check("ovf held", ovf, ovf_m);
            end else begin
                check("no done mid-run", done, 0);
                check("busy mid-run", busy, 1);
            end
        end
    endtask

    task automatic set_ops(input int n, input int gap_max);
        for (int i = 0; i < 16; i++) begin
            ops_buf[i] = (i < n) ? ((($urandom_range(0, 3) == 0) ? $urandom_range(200, MAXV)
                                                               : $urandom_range(0, MAXV))) : 0;
            gap_buf[i] = $urandom_range(0, gap_max);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        num_ops  = '0;
        op_valid = 1'b0;
        op_data  = '0;
        #1;
        check_all_zero("reset");
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);

        // 1: three small operands, no carry.
        set_ops(0, 0);
        ops_buf[0] = 'h10; ops_buf[1] = 'h20; ops_buf[2] = 'h05;
        run(3, 0, 1'b0);
        check("directed sum 0x35", result, 'h35);

        // 2: carry out of the top bit.
        set_ops(0, 0);
        ops_buf[0] = 'hF0; ops_buf[1] = 'h20;
        run(2, 0, 1'b0);
`ifdef ACCUM_SAT_EN
        check("directed overflow result", result, 'hFF);
`else
        check("directed overflow result", result, 'h10);
`endif
        check("directed overflow flag", ovf, 1);

        // 3: zero operands.
        run(0, 0, 1'b0);

        // 4: long wait before the first operand.
        set_ops(0, 0);
        ops_buf[0] = 'h07; gap_buf[0] = 5;
        run(1, 0, 1'b0);
        check("after wait acc", result, 'h07);

        // 5: start pulsed mid-run is ignored.
        set_ops(0, 0);
        ops_buf[0] = 'h01; ops_buf[1] = 'h02; ops_buf[2] = 'h03; gap_buf[1] = 2;
        run(3, 0, 1'b1);
        check("mid-run start ignored", result, 'h06);

        // 6: reset after the first operand of three.
        set_ops(3, 0);
        ops_buf[0] = 'h11;
        gap_buf[1] = 1;
        run(3, 1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_all_zero("mid-run reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("no done during reset", done, 0);
        end
        reset = 1'b0;
        @(negedge Clk);
        check_all_zero("after reset release");
        set_ops(3, 1);
        run(3, 0, 1'b0);

        // Randomised runs.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(0, (1 << CNT_W) - 1);
            set_ops(n, 3);
            run(n, 0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
